// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus iterative MUL/MULHU/DIVU/REMU.
// One operation in flight; results are registered and held until the consumer takes them.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             err
);

    localparam int unsigned SH = $clog2(WIDTH);
    localparam int unsigned CW = SH + 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

    state_t             r_state, w_state_d;
    logic [CW-1:0]      r_cnt, w_cnt_d;
    logic [3:0]         r_op, w_op_d;
    logic [2*WIDTH-1:0] r_mcand, w_mcand_d;
    logic [WIDTH-1:0]   r_mplier, w_mplier_d;
    logic [2*WIDTH-1:0] r_acc, w_acc_d;
    logic [WIDTH:0]     r_rem, w_rem_d;
    logic [WIDTH-1:0]   r_quo, w_quo_d;
    logic [WIDTH-1:0]   r_div, w_div_d;
    logic [WIDTH-1:0]   r_result, w_result_d;
    logic               r_zero, w_zero_d;
    logic               r_err, w_err_d;

    logic               w_multi, w_illegal, w_lt_s;
    logic [WIDTH-1:0]   w_single, w_final;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH:0]     w_shift, w_trial, w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;

    assign w_multi   = (alu_sel >= 4'd10) && (alu_sel <= 4'd13);
    assign w_illegal = (alu_sel >= 4'd14);
    assign w_lt_s    = $signed(in_A) < $signed(in_B);

    always_comb begin
        w_single = '0;
        case (alu_sel)
            4'd0:    w_single = in_A + in_B;
            4'd1:    w_single = in_A - in_B;
            4'd2:    w_single = in_A & in_B;
            4'd3:    w_single = in_A | in_B;
            4'd4:    w_single = in_A ^ in_B;
            4'd5:    w_single = {{(WIDTH-1){1'b0}}, (in_A < in_B)};
            4'd6:    w_single = in_A << in_B[SH-1:0];
            4'd7:    w_single = in_A >> in_B[SH-1:0];
            4'd8:    w_single = {{(WIDTH-1){1'b0}}, w_lt_s};
            4'd9:    w_single = $unsigned($signed(in_A) >>> in_B[SH-1:0]);
            default: w_single = '0;
        endcase
    end

    // Shift-add multiply: multiplicand walks left, multiplier walks right.
    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Restoring divide; a divisor of zero naturally yields all-ones quotient and remainder = A.
    assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_rem_step = w_trial[WIDTH] ? w_shift : w_trial;
    assign w_quo_step = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    always_comb begin
        w_final = '0;
        case (r_op)
            4'd10:   w_final = w_acc_step[WIDTH-1:0];
            4'd11:   w_final = w_acc_step[2*WIDTH-1:WIDTH];
            4'd12:   w_final = w_quo_step;
            default: w_final = w_rem_step[WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_op_d     = r_op;
        w_mcand_d  = r_mcand;
        w_mplier_d = r_mplier;
        w_acc_d    = r_acc;
        w_rem_d    = r_rem;
        w_quo_d    = r_quo;
        w_div_d    = r_div;
        w_result_d = r_result;
        w_zero_d   = r_zero;
        w_err_d    = r_err;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    if (w_multi) begin
                        w_op_d     = alu_sel;
                        w_cnt_d    = '0;
                        w_mcand_d  = {{WIDTH{1'b0}}, in_A};
                        w_mplier_d = in_B;
                        w_acc_d    = '0;
                        w_rem_d    = '0;
                        w_quo_d    = in_A;
                        w_div_d    = in_B;
                        w_state_d  = StExec;
                    end else begin
                        w_result_d = w_single;
                        w_zero_d   = w_illegal ? 1'b1 : (w_single == '0);
                        w_err_d    = w_illegal;
                        w_state_d  = StDone;
                    end
                end
            end
            StExec: begin
                w_acc_d    = w_acc_step;
                w_mcand_d  = r_mcand << 1;
                w_mplier_d = r_mplier >> 1;
                w_rem_d    = w_rem_step;
                w_quo_d    = w_quo_step;
                w_cnt_d    = r_cnt + 1'b1;
                if (r_cnt == LastCnt) begin
                    w_cnt_d    = r_cnt;
                    w_result_d = w_final;
                    w_zero_d   = (w_final == '0);
                    w_err_d    = 1'b0;
                    w_state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_op     <= w_op_d;
            r_mcand  <= w_mcand_d;
            r_mplier <= w_mplier_d;
            r_acc    <= w_acc_d;
            r_rem    <= w_rem_d;
            r_quo    <= w_quo_d;
            r_div    <= w_div_d;
            r_result <= w_result_d;
            r_zero   <= w_zero_d;
            r_err    <= w_err_d;
        end
    end

    assign in_ready   = (r_state == StIdle);
    assign out_valid  = (r_state == StDone);
    assign alu_result = r_result;
    assign zero       = r_zero;
    assign err        = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed plan cases, backpressure, mid-op reset,
// then randomized ops compared with an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_A;
    logic [W-1:0] in_B;
    logic [3:0]   alu_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         err;

    int n_checks;
    int n_errors;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_A       (in_A),
        .in_B       (in_B),
        .alu_sel    (alu_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero       (zero),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {err, zero, result}, computed from the op definitions with wide arithmetic.
    function automatic logic [33:0] ref_alu(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] wa, wb, wide;
        logic [31:0] r;
        wa = {32'b0, a};
        wb = {32'b0, b};
        r  = 32'h0;
        case (sel)
            4'd0:  begin wide = wa + wb;  r = wide[31:0]; end
            4'd1:  begin wide = wa - wb;  r = wide[31:0]; end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = (wa < wb) ? 32'd1 : 32'd0;
            4'd6:  begin wide = wa << b[4:0]; r = wide[31:0]; end
            4'd7:  r = a >> b[4:0];
            4'd8:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9:  begin wide = {{32{a[31]}}, a} >> b[4:0]; r = wide[31:0]; end
            4'd10: begin wide = wa * wb; r = wide[31:0]; end
            4'd11: begin wide = wa * wb; r = wide[63:32]; end
            4'd12: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: r = (b == 0) ? a : a % b;
            default: return {1'b1, 1'b1, 32'h0};
        endcase
        return {1'b0, (r == 32'h0), r};
    endfunction

    // Issue one op, check latency and result, hold backpressure for 'hold' cycles, then drain.
    task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [33:0] exp;
        int          lat;
        int          want;
        exp  = ref_alu(sel, a, b);
        want = (sel >= 4'd10 && sel <= 4'd13) ? int'(W) + 1 : 1;
        @(negedge clk);
        check("in_ready_idle", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1;
        alu_sel  = sel;
        in_A     = a;
        in_B     = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_A     = $urandom;
        in_B     = $urandom;
        alu_sel  = 4'($urandom);
        lat      = 1;
        while (!out_valid && lat < 200) begin
            check("in_ready_busy", {63'b0, in_ready}, 64'd0);
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", sel), 64'(lat), 64'(want));
        check($sformatf("result op%0d a=%h b=%h", sel, a, b), {32'b0, alu_result},
              {32'b0, exp[31:0]});
        check($sformatf("zero op%0d", sel), {63'b0, zero}, {63'b0, exp[32]});
        check($sformatf("err op%0d", sel), {63'b0, err}, {63'b0, exp[33]});
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            alu_sel  = 4'($urandom);
            in_A     = $urandom;
            in_B     = $urandom;
            @(negedge clk);
            check("bp_valid", {63'b0, out_valid}, 64'd1);
            check("bp_in_ready", {63'b0, in_ready}, 64'd0);
            check("bp_result", {32'b0, alu_result}, {32'b0, exp[31:0]});
            check("bp_flags", {62'b0, err, zero}, {62'b0, exp[33:32]});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", {63'b0, out_valid}, 64'd0);
        check("drain_in_ready", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [3:0]  rsel;
        logic [31:0] ra, rb;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_A      = '0;
        in_B      = '0;
        alu_sel   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_result", {32'b0, alu_result}, 64'd0);
        check("rst_flags", {62'b0, err, zero}, 64'd0);
        rst_n = 1'b1;

        run_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'd1, 32'd5, 32'd7, 0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'd9, 32'h8000_0000, 32'h0000_0024, 0);
        run_op(4'd6, 32'h0000_0001, 32'h0000_0021, 0);
        run_op(4'd7, 32'hF000_0000, 32'h0000_0044, 0);
        run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(4'd11, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(4'd12, 32'd100, 32'd7, 0);
        run_op(4'd13, 32'd100, 32'd7, 0);
        run_op(4'd12, 32'h1234_5678, 32'd0, 0);
        run_op(4'd13, 32'd5, 32'd0, 0);
        run_op(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 10);
        run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);

        // Reset in the middle of a divide.
        @(negedge clk);
        in_valid = 1'b1;
        alu_sel  = 4'd12;
        in_A     = 32'd1000;
        in_B     = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_result", {32'b0, alu_result}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        run_op(4'd0, 32'd2, 32'd3, 0);
        run_op(4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(4'hF, 32'h0, 32'h0, 2);

        for (int i = 0; i < 40; i++) begin
            rsel = 4'($urandom_range(0, 15));
            ra   = $urandom;
            rb   = $urandom;
            if (i % 5 == 1) rb = $urandom_range(0, 9);
            if (i % 7 == 2) ra = 32'hFFFF_FFFF;
            run_op(rsel, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU with an iterative multiply/divide unit; the successor to the single-cycle 32-bit ALU. It takes WIDTH-bit operands and a 4-bit operation code through a valid/ready input port and returns a registered result, zero flag and error flag through a valid/ready output port. Logic/arithmetic ops complete in one cycle; MUL/MULHU/DIVU/REMU iterate one bit per cycle. It sits between decode/operand fetch and writeback in multi-cycle core variants.

## Interface
- WIDTH, 32, operand/result width; power of two, 8 to 64
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  block can accept; equals (state == IDLE)
- in_A  in  WIDTH  first operand
- in_B  in  WIDTH  second operand
- alu_sel  in  4  operation code
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer takes result
- alu_result  out  WIDTH  result, registered
- zero  out  1  alu_result == 0, registered with result
- err  out  1  illegal alu_sel, registered with result

## Operation
- Op codes (codes 0-7 keep the legacy 3-bit meaning): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLTU, 6 SLL, 7 SRL, 8 SLT (signed), 9 SRA, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU, 14-15 illegal.
- Add/sub wrap modulo 2^WIDTH; no carry/overflow output.
- Shifts use in_B[log2(WIDTH)-1:0] only; upper bits ignored.
- SLT/SLTU result is 1 or 0, zero-extended.
- Divide by zero: DIVU = all ones, REMU = in_A; err stays 0.
- Illegal op: alu_result = 0, zero = 1, err = 1; single-cycle path.
- Operands and op are captured on accept (in_valid && in_ready); later changes on the input port are ignored.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: on accept of ops 0-9/14-15, compute and register the result, go to DONE. On accept of ops 10-13, load the datapath, clear the counter, go to EXEC.
  - EXEC: one iteration per cycle. Multiply is shift-add into a 2*WIDTH accumulator. Divide is restoring, with a WIDTH+1-bit partial remainder. After WIDTH iterations, register the selected result and go to DONE.
  - DONE: out_valid = 1. On out_ready go to IDLE on the next edge.
- Iteration counter is log2(WIDTH)+1 bits wide and counts 0..WIDTH-1.
- Reset: synchronous, abandons any operation. Post-reset values: state IDLE, in_ready 1, out_valid 0, alu_result 0, zero 0, err 0, counter and datapath registers 0.
- No X on any output in any state.

## Timing
- Single-cycle ops: accepted at edge N, out_valid = 1 after edge N+1.
- Multi-cycle ops: accepted at edge N, out_valid = 1 after edge N+WIDTH+1 (33 cycles for WIDTH=32).
- Results are independent of out_ready; backpressure only extends DONE.
- alu_result, zero and err change only on the edge that enters DONE, and stay stable while out_valid && !out_ready.
- in_ready = 0 in EXEC and DONE. The output transfer and the next accept never happen in the same cycle.
- Minimum accept-to-accept spacing: 3 cycles for single-cycle ops with out_ready tied high.
- rst_n low takes priority over every other event, including an output transfer in the same cycle.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 -> alu_result 0x00000000, zero 1, err 0, out_valid exactly 1 cycle after accept. SUB 5 - 7 -> 0xFFFFFFFE.
- SLT 0xFFFFFFFF vs 0x00000001 -> 1. SLTU on the same operands -> 0. SRA 0x80000000 by in_B=0x24 -> 0xF8000000. SLL 0x1 by 0x21 -> 0x2.
- MUL 0x00010000 * 0x00010000 -> 0x00000000 with zero 1. MULHU on the same operands -> 0x00000001. out_valid first high exactly 33 cycles after accept; in_ready low throughout.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 0x12345678/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. err 0 in all four cases.
- Backpressure: out_ready low for 10 cycles after DONE -> result, zero and err stable, in_ready 0, competing in_valid pulses ignored. Then out_ready high for 1 cycle -> in_ready 1 on the next cycle.
- rst_n low for 1 cycle at cycle 10 of a DIVU -> next cycle out_valid 0, alu_result 0, in_ready 1. A following ADD 2+3 returns 5 normally. Illegal op 0xE -> alu_result 0, zero 1, err 1.
